// File: rtl/column_mux_pkg.sv
// Shared types, default constants and the row-pattern helper for the LED-matrix row multiplexer.
package column_mux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DEAD  = 2'd1,
        ST_ON    = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    localparam int DEF_NB_MUX         = 8;
    localparam int DEF_DEAD_CYCLES    = 4;
    localparam int DEF_TIMEOUT_CYCLES = 4096;
    localparam int MAX_MUX            = 64;

    // Bits at or above nb are zero; callers cast the result down to their row count.
    function automatic logic [MAX_MUX-1:0] row_onehot(input int unsigned idx, input logic on,
                                                      input int unsigned nb, input logic active_low);
        logic [MAX_MUX-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < MAX_MUX; i++) begin
            if (i < nb) begin
                v[i] = (on && (i == idx)) ^ active_low;
            end else begin
                v[i] = 1'b0;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/column_mux_if.sv
// Row-multiplexer bus: controller-side strobes in, row switch drive and status out.
interface column_mux_if #(parameter int NB_MUX = 8);
    localparam int IDX_W = $clog2(NB_MUX);

    logic              column_ready;
    logic              position_sync;
    logic              display_en;
    logic [NB_MUX-1:0] mux_out;
    logic [IDX_W-1:0]  mux_index;
    logic              blanked;
    logic              watchdog_fault;

    modport master (
        output column_ready, position_sync, display_en,
        input  mux_out, mux_index, blanked, watchdog_fault
    );

    modport slave (
        input  column_ready, position_sync, display_en,
        output mux_out, mux_index, blanked, watchdog_fault
    );
endinterface

// File: rtl/column_mux_watchdog.sv
// Enabled cycle counter for the ON state; raises timeout while the last allowed cycle is running.
module mux_watchdog #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic clk,
    input  logic nrst,
    input  logic clk_enable,
    input  logic clear,
    input  logic run,
    output logic timeout
);
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CW-1:0] cnt_r;

    // Counter register: clear wins over run, nothing moves without clk_enable.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            cnt_r <= '0;
        end else if (clk_enable) begin
            if (clear) begin
                cnt_r <= '0;
            end else if (run) begin
                cnt_r <= cnt_r + 1'b1;
            end else begin
                cnt_r <= cnt_r;
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign timeout = run && (cnt_r == CW'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/column_mux.sv
// LED-matrix row multiplexer: dead-time between rows, slice realignment and a stall watchdog.
module column_mux
    import column_mux_pkg::*;
#(
    parameter int NB_MUX         = DEF_NB_MUX,
    parameter int DEAD_CYCLES    = DEF_DEAD_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int MUX_ACTIVE_LOW = 1
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         clk_enable,
    column_mux_if.slave  bus
);
    localparam int   IW  = $clog2(NB_MUX);
    localparam int   DW  = $clog2(DEAD_CYCLES) + 1;
    localparam logic ALO = (MUX_ACTIVE_LOW != 0);

    state_t            state_r, state_next_s;
    logic [IW-1:0]     next_idx_r, next_idx_next_s;
    logic [IW-1:0]     pending_r, pending_next_s, target_s;
    logic [DW-1:0]     dead_cnt_r, dead_next_s;
    logic [NB_MUX-1:0] mux_out_r, mux_next_s;
    logic [IW-1:0]     mux_index_r, idx_next_s;
    logic              blanked_r, fault_r;
    logic              timeout_s;

    mux_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wd (
        .clk        (clk),
        .nrst       (nrst),
        .clk_enable (clk_enable),
        .clear      (state_r != ST_ON),
        .run        (state_r == ST_ON),
        .timeout    (timeout_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_r <= ST_IDLE;
        end else if (clk_enable) begin
            state_r <= state_next_s;
        end else begin
            state_r <= state_r;
        end
    end

    // Next-state: display_en dominates, then a row-select event, then dead-time/watchdog expiry.
    always_comb begin
        state_next_s    = state_r;
        pending_next_s  = pending_r;
        next_idx_next_s = next_idx_r;
        dead_next_s     = dead_cnt_r;
        if (bus.position_sync) begin
            target_s = '0;
        end else begin
            target_s = next_idx_r;
        end
        if (!bus.display_en) begin
            state_next_s    = ST_IDLE;
            next_idx_next_s = '0;
            dead_next_s     = '0;
        end else if (bus.column_ready) begin
            state_next_s   = ST_DEAD;
            dead_next_s    = '0;
            pending_next_s = target_s;
            if (bus.position_sync) begin
                next_idx_next_s = IW'(1);
            end else begin
                next_idx_next_s = next_idx_r + 1'b1;
            end
        end else begin
            if (bus.position_sync) begin
                next_idx_next_s = '0;
            end else begin
                next_idx_next_s = next_idx_r;
            end
            case (state_r)
                ST_DEAD: begin
                    if (dead_cnt_r == DW'(DEAD_CYCLES - 1)) begin
                        state_next_s = ST_ON;
                        dead_next_s  = '0;
                    end else begin
                        dead_next_s = dead_cnt_r + 1'b1;
                    end
                end
                ST_ON: begin
                    if (timeout_s) begin
                        state_next_s = ST_FAULT;
                    end else begin
                        state_next_s = ST_ON;
                    end
                end
                default: state_next_s = state_r;
            endcase
        end
    end

    // Output pattern follows the next state so the row switches stay registered.
    always_comb begin
        mux_next_s = NB_MUX'(row_onehot(32'd0, 1'b0, NB_MUX, ALO));
        idx_next_s = mux_index_r;
        if (state_next_s == ST_ON) begin
            if (state_r == ST_ON) begin
                mux_next_s = mux_out_r;
            end else begin
                mux_next_s = NB_MUX'(row_onehot(32'(pending_r), 1'b1, NB_MUX, ALO));
                idx_next_s = pending_r;
            end
        end else begin
            idx_next_s = mux_index_r;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            next_idx_r  <= '0;
            pending_r   <= '0;
            dead_cnt_r  <= '0;
            mux_out_r   <= NB_MUX'(row_onehot(32'd0, 1'b0, NB_MUX, ALO));
            mux_index_r <= '0;
            blanked_r   <= 1'b1;
            fault_r     <= 1'b0;
        end else if (clk_enable) begin
            next_idx_r  <= next_idx_next_s;
            pending_r   <= pending_next_s;
            dead_cnt_r  <= dead_next_s;
            mux_out_r   <= mux_next_s;
            mux_index_r <= idx_next_s;
            blanked_r   <= (state_next_s != ST_ON);
            fault_r     <= (state_next_s == ST_FAULT);
        end else begin
            next_idx_r  <= next_idx_r;
            pending_r   <= pending_r;
            dead_cnt_r  <= dead_cnt_r;
            mux_out_r   <= mux_out_r;
            mux_index_r <= mux_index_r;
            blanked_r   <= blanked_r;
            fault_r     <= fault_r;
        end
    end

    assign bus.mux_out        = mux_out_r;
    assign bus.mux_index      = mux_index_r;
    assign bus.blanked        = blanked_r;
    assign bus.watchdog_fault = fault_r;
endmodule

// File: tb/tb_column_mux.sv
// Self-checking bench for column_mux: directed scenarios plus a random phase against an event-level model.
module tb_column_mux;
    localparam int NB = 8;
    localparam int DC = 4;
    localparam int TO = 4096;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    logic clk_enable = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    // Model: which row is lit (-1 none), countdown to lighting, time lit, slice position.
    int m_show, m_cd, m_pend, m_on, m_next, m_idx;
    bit m_fault;

    column_mux_if #(.NB_MUX(NB)) bus ();

    column_mux #(.NB_MUX(NB), .DEAD_CYCLES(DC), .TIMEOUT_CYCLES(TO), .MUX_ACTIVE_LOW(1)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .clk_enable (clk_enable),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_show = -1; m_cd = 0; m_pend = 0; m_on = 0; m_next = 0; m_idx = 0; m_fault = 1'b0;
    endtask

    task automatic model_step(input logic cr, input logic ps, input logic de);
        if (!de) begin
            m_show = -1; m_cd = 0; m_next = 0; m_fault = 1'b0;
        end else if (cr) begin
            m_pend  = ps ? 0 : m_next;
            m_next  = ps ? 1 : (m_next + 1) % NB;
            m_cd    = DC;
            m_show  = -1;
            m_fault = 1'b0;
        end else begin
            if (ps) m_next = 0;
            if (m_cd > 0) begin
                m_cd--;
                if (m_cd == 0) begin
                    m_show = m_pend; m_idx = m_pend; m_on = 0;
                end
            end else if (m_show >= 0) begin
                m_on++;
                if (m_on == TO) begin
                    m_show = -1; m_fault = 1'b1;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [NB-1:0] exp_mux;
        exp_mux = (m_show >= 0) ? ~(NB'(1) << m_show) : {NB{1'b1}};
        chk("mux_out", 32'(bus.mux_out), 32'(exp_mux));
        chk("blanked", 32'(bus.blanked), 32'(m_show < 0));
        chk("watchdog_fault", 32'(bus.watchdog_fault), 32'(m_fault));
        if (m_show >= 0) chk("mux_index", 32'(bus.mux_index), 32'(m_idx));
    endtask

    task automatic step(input logic cr, input logic ps, input logic de, input logic ce);
        bus.column_ready  = cr;
        bus.position_sync = ps;
        bus.display_en    = de;
        clk_enable        = ce;
        @(posedge clk);
        if (!nrst) model_reset();
        else if (ce) model_step(cr, ps, de);
        #1;
        check_all();
    endtask

    initial begin
        model_reset();
        bus.column_ready = 1'b0; bus.position_sync = 1'b0; bus.display_en = 1'b0;
        nrst = 1'b0;
        step(0, 0, 0, 0);
        step(0, 0, 1, 1);
        chk("reset_mux_out", 32'(bus.mux_out), 32'hFF);
        chk("reset_mux_index", 32'(bus.mux_index), 32'd0);
        nrst = 1'b1;

        // Rows 0..7 then 0 again, one event every 513 cycles.
        for (int r = 0; r < 9; r++) begin
            step(1, 0, 1, 1);
            repeat (3) step(0, 0, 1, 1);
            chk("blanked_before_row", 32'(bus.blanked), 32'd1);
            step(0, 0, 1, 1);
            if (r == 0) chk("row0_pattern", 32'(bus.mux_out), 32'hFE);
            chk("row_order", 32'(bus.mux_index), 32'(r % NB));
            repeat (508) step(0, 0, 1, 1);
        end

        // Walk next_idx to 5, then sync together with column_ready.
        step(0, 1, 1, 1);
        repeat (5) begin
            step(1, 0, 1, 1);
            repeat (6) step(0, 0, 1, 1);
        end
        step(1, 1, 1, 1);
        repeat (6) step(0, 0, 1, 1);
        chk("sync_row0", 32'(bus.mux_index), 32'd0);
        step(1, 0, 1, 1);
        repeat (6) step(0, 0, 1, 1);
        chk("after_sync_row1", 32'(bus.mux_index), 32'd1);

        // Second event on the second dead cycle restarts dead time.
        step(1, 0, 1, 1);
        step(0, 0, 1, 1);
        step(1, 0, 1, 1);
        repeat (3) step(0, 0, 1, 1);
        chk("restart_still_blank", 32'(bus.blanked), 32'd1);
        step(0, 0, 1, 1);
        chk("restart_second_row", 32'(bus.mux_index), 32'd3);

        // clk_enable toggling; column_ready during disabled cycles must be ignored.
        for (int i = 0; i < 16; i++) begin
            step((i == 0) || (i % 2 == 1), 0, 1, (i % 2 == 0));
        end

        // Watchdog expiry and recovery.
        repeat (TO + 4) step(0, 0, 1, 1);
        chk("wd_fault", 32'(bus.watchdog_fault), 32'd1);
        step(1, 0, 1, 1);
        chk("wd_cleared", 32'(bus.watchdog_fault), 32'd0);
        repeat (6) step(0, 0, 1, 1);

        // display_en drop while row 3 is lit.
        step(0, 1, 1, 1);
        repeat (4) begin
            step(1, 0, 1, 1);
            repeat (5) step(0, 0, 1, 1);
        end
        chk("row3_lit", 32'(bus.mux_index), 32'd3);
        step(0, 0, 0, 1);
        chk("disable_blank", 32'(bus.mux_out), 32'hFF);
        step(1, 0, 1, 1);
        repeat (5) step(0, 0, 1, 1);
        chk("reenable_row0", 32'(bus.mux_index), 32'd0);

        // Randomized traffic with one mid-operation reset under clk_enable=0.
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                nrst = 1'b0;
                step(0, 0, 1, 0);
                nrst = 1'b1;
            end
            step($urandom_range(11, 0) == 0, $urandom_range(39, 0) == 0,
                 $urandom_range(99, 0) != 0, $urandom_range(3, 0) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
